// File: rtl/ysyx_23060025_wbu_q.sv
// Buffered write-back unit: in-order queue between LSU and RF/CSR commit, x0 suppression, sticky ebreak halt.
// Define YSYX_23060025_WBU_RETIRE_CNT_EN to add the 64-bit retired-instruction counter output retire_cnt_o.
module ysyx_23060025_wbu_q #(
  parameter int DATA_LEN = 32,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                lsu_valid_i,
  output logic                wbu_ready_o,
  input  logic                wd_i,
  input  logic [REG_AW-1:0]   wreg_i,
  input  logic [DATA_LEN-1:0] reg_wdata_i,
  input  logic [2:0]          csr_type_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  input  logic                ebreak_flag_i,
  input  logic                commit_ready_i,
  output logic                rf_we_o,
  output logic [REG_AW-1:0]   rf_waddr_o,
  output logic [DATA_LEN-1:0] rf_wdata_o,
  output logic [2:0]          csr_type_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                retire_o,
  output logic                halt_o
`ifdef YSYX_23060025_WBU_RETIRE_CNT_EN
  ,
  output logic [63:0]         retire_cnt_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  typedef struct packed {
    logic                wd;
    logic [REG_AW-1:0]   wreg;
    logic [DATA_LEN-1:0] reg_wdata;
    logic [2:0]          csr_type;
    logic [DATA_LEN-1:0] csr_wdata;
    logic                ebreak;
  } entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t        state_reg;
  entry_t        q_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;

  entry_t        in_entry;
  entry_t        head;
  logic          full;
  logic          empty;
  logic          push;
  logic          commit;

  assign halt_o      = (state_reg == HALT);
  assign full        = (count_reg == FULL_COUNT);
  assign empty       = (count_reg == '0);
  assign wbu_ready_o = !full && !halt_o;
  assign push        = lsu_valid_i && wbu_ready_o && !reset;
  // Nothing retires while reset is held, even if entries were queued before it.
  assign commit      = !empty && commit_ready_i && !halt_o && !reset;

  assign in_entry.wd        = wd_i;
  assign in_entry.wreg      = wreg_i;
  assign in_entry.reg_wdata = reg_wdata_i;
  assign in_entry.csr_type  = csr_type_i;
  assign in_entry.csr_wdata = csr_wdata_i;
  assign in_entry.ebreak    = ebreak_flag_i;

  // Payload storage carries no reset: validity is tracked solely by the pointers and count.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          q_reg[gi] <= in_entry;
        end
      end
    end
  endgenerate

  assign head = q_reg[rd_ptr_reg];

  always_comb begin
    rf_we_o     = 1'b0;
    rf_waddr_o  = '0;
    rf_wdata_o  = '0;
    csr_type_o  = 3'd0;
    csr_wdata_o = '0;
    retire_o    = 1'b0;
    if (commit) begin
      rf_we_o     = head.wd && (head.wreg != '0);
      rf_waddr_o  = head.wreg;
      rf_wdata_o  = head.reg_wdata;
      csr_type_o  = head.csr_type;
      csr_wdata_o = head.csr_wdata;
      retire_o    = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      state_reg  <= RUN;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (commit) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, commit})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      case (state_reg)
        RUN:     if (commit && head.ebreak) state_reg <= HALT;
        HALT:    state_reg <= HALT;
        default: state_reg <= RUN;
      endcase
    end
  end

`ifdef YSYX_23060025_WBU_RETIRE_CNT_EN
  logic [63:0] retire_cnt_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt_reg <= '0;
    end else if (retire_o) begin
      retire_cnt_reg <= retire_cnt_reg + 64'd1;
    end
  end

  assign retire_cnt_o = retire_cnt_reg;
`endif

endmodule
